// File: rtl/pipe_ram.sv
// pipe_ram: simple dual-port RAM with pipelined reads, optional post-reset clear and sticky error flag
// Ports: clk, rst (sync, active-high); port A write (wea, addra, dina);
//        port B read (reb, addrb -> doutb, doutb_vld after RD_LAT cycles);
//        init_busy (clear in progress), err (sticky access error).
module pipe_ram #(
  parameter int DW          = 272,
  parameter int DEPTH       = 141,
  parameter int AW          = 8,
  parameter int RD_LAT      = 3,
  parameter int WRITE_FIRST = 0,
  parameter int INIT_CLEAR  = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wea,
  input  logic [AW-1:0] addra,
  input  logic [DW-1:0] dina,
  input  logic          reb,
  input  logic [AW-1:0] addrb,
  output logic [DW-1:0] doutb,
  output logic          doutb_vld,
  output logic          init_busy,
  output logic          err
);
  typedef enum logic {INIT, READY} state_t;
  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] LAST    = AW'(DEPTH - 1);
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] dat_q [RD_LAT];
  logic [RD_LAT-1:0] vld_q;
  logic          ready, wa_ok, rb_ok, wr_en, rd_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data, rd_data;
  always_comb begin
    ready   = state_q == READY;
    wa_ok   = {1'b0, addra} < DEPTH_W;
    rb_ok   = {1'b0, addrb} < DEPTH_W;
    state_d = (state_q == INIT && cnt_q == LAST) ? READY : state_q;
    cnt_d   = ready ? cnt_q : cnt_q + AW'(1);
    // the clear sequence owns the write port while INIT
    wr_en   = !ready || (wea && wa_ok);
    wr_addr = ready ? addra : cnt_q;
    wr_data = ready ? dina : '0;
    rd_en   = ready && reb;
    rd_data = !rb_ok ? '0 : (WRITE_FIRST != 0 && wea && addra == addrb) ? dina : mem[addrb];
    err_d   = err_q | (ready ? ((wea && !wa_ok) || (reb && !rb_ok)) : (wea || reb));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= INIT_CLEAR != 0 ? INIT : READY;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= '0;
      dat_q   <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      vld_q[0] <= rd_en;
      if (rd_en) dat_q[0] <= rd_data;
      // stages load only on valid data so the last stage holds between reads
      for (int i = 1; i < RD_LAT; i++) begin
        vld_q[i] <= vld_q[i-1];
        if (vld_q[i-1]) dat_q[i] <= dat_q[i-1];
      end
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && wr_en) mem[wr_addr] <= wr_data;
  end
  assign doutb     = dat_q[RD_LAT-1];
  assign doutb_vld = vld_q[RD_LAT-1];
  assign init_busy = state_q == INIT;
  assign err       = err_q;
endmodule

// File: doc/pipe_ram.md
PIPE_RAM -- requirements
Module: pipe_ram

Interface
REQ-001 Parameter DW, default 272, data width in bits (>=1).
REQ-002 Parameter DEPTH, default 141, number of words (2..2**AW).
REQ-003 Parameter AW, default 8, address width in bits.
REQ-004 Parameter RD_LAT, default 3, read latency in cycles (1..8).
REQ-005 Parameter WRITE_FIRST, default 0: 0 = same-address collision returns old data, 1 = returns dina.
REQ-006 Parameter INIT_CLEAR, default 1: 1 = zero all words after reset, 0 = no clear.
REQ-007 Port clk  in  1  single clock; all state changes on its rising edge.
REQ-008 Port rst  in  1  reset, synchronous, active-high.
REQ-009 Port wea  in  1  write enable, port A.
REQ-010 Port addra  in  AW  write address.
REQ-011 Port dina  in  DW  write data.
REQ-012 Port reb  in  1  read enable, port B.
REQ-013 Port addrb  in  AW  read address.
REQ-014 Port doutb  out  DW  read data.
REQ-015 Port doutb_vld  out  1  doutb carries the result of a read this cycle.
REQ-016 Port init_busy  out  1  clear sequence in progress; port accesses ignored.
REQ-017 Port err  out  1  sticky access-error flag.

Function
REQ-018 The controller SHALL have exactly two states: INIT and READY.
REQ-019 While rst=1, the state SHALL be INIT (INIT_CLEAR=1) or READY (INIT_CLEAR=0), and the clear counter SHALL be 0.
REQ-020 In INIT, the k-th cycle after rst deasserts (k=0..DEPTH-1) SHALL write zero to address k.
REQ-021 INIT SHALL go to READY after the write to address DEPTH-1; init_busy SHALL be 1 exactly while in INIT.
REQ-022 In INIT, wea and reb SHALL be ignored; any asserted wea or reb SHALL set err.
REQ-023 In READY, wea=1 with addra<DEPTH SHALL write dina to addra on that edge.
REQ-024 In READY, wea=1 with addra>=DEPTH SHALL drop the write and set err.
REQ-025 In READY, reb=1 at cycle t SHALL sample memory at addrb on that edge and present the data on doutb with doutb_vld=1 at cycle t+RD_LAT.
REQ-026 Reads SHALL be fully pipelined: one read accepted per cycle, no back-pressure, no reordering.
REQ-027 A read with addrb>=DEPTH SHALL return all-zero data with doutb_vld=1 and set err.
REQ-028 Same-cycle wea & reb with addra==addrb<DEPTH SHALL return dina if WRITE_FIRST=1, else the prior word; the write SHALL always occur.
REQ-029 Writes after a read is sampled SHALL NOT alter that read's in-flight data.
REQ-030 When doutb_vld=0, doutb SHALL hold its last value.
REQ-031 err SHALL stay set until rst.

Reset
REQ-032 On rst=1: doutb=0, doutb_vld=0, all pipeline valid stages=0, err=0, init_busy=1 (INIT_CLEAR=1) or 0 (INIT_CLEAR=0).
REQ-033 rst asserted mid-INIT SHALL restart the clear from address 0.
REQ-034 rst asserted mid-read SHALL discard in-flight reads; no doutb_vld pulse SHALL follow for them.
REQ-035 With INIT_CLEAR=0, memory contents SHALL be unaffected by rst.

Verification
REQ-036 Defaults, release rst at cycle 0 -> init_busy=1 for cycles 0..140 and 0 from cycle 141; a read of every address returns 0; err=0.
REQ-037 Write 0xA5 at addr 7, then reb addr 7 one cycle later -> doutb=0xA5, doutb_vld=1 exactly 3 cycles after reb.
REQ-038 Back-to-back reads of addrs 0,1,2 holding 0x11,0x22,0x33 -> doutb_vld high 3 consecutive cycles with 0x11,0x22,0x33 in order.
REQ-039 Addr 5 holds 0x1; same cycle wea addr 5 dina 0x2 and reb addr 5 -> doutb=0x1 (WRITE_FIRST=0) or 0x2 (WRITE_FIRST=1); a later read returns 0x2.
REQ-040 wea at addra=200 and reb at addrb=141 -> err=1 and stays 1; that read returns 0 with doutb_vld=1; no in-range word changes.
REQ-041 rst pulsed at INIT cycle 50, then after 141 clear cycles, and rst pulsed with 2 reads in flight -> clear restarts at address 0; no doutb_vld for the flushed reads.
